casu_er_cfg: RTL and testbench



---
 rtl/casu_er_cfg.sv | 167 ++++++++++++++++
 tb/tb_casu_er_cfg.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/casu_er_cfg.sv
// ============================================================================
// Module   : casu_er_cfg
// Brief    : Shadowed, validated ER_min/ER_max configuration for the CASU
//            monitor. Optional lock feature: CASU_ER_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module casu_er_cfg #(
    parameter logic [15:0] CFG_BASE  = 16'h0140,
    parameter logic [15:0] SMEM_BASE = 16'hA000,
    parameter logic [15:0] SMEM_SIZE = 16'h4000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [15:0] ER_min,
    output logic [15:0] ER_max,
    output logic        er_valid
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_CHECK  = 2'd1;
    localparam logic [1:0]  ST_APPLY  = 2'd2;
    localparam logic [1:0]  ST_ERR    = 2'd3;

    localparam logic [1:0]  OFF_SH_MIN = 2'd0;
    localparam logic [1:0]  OFF_SH_MAX = 2'd1;
    localparam logic [1:0]  OFF_CTRL   = 2'd2;
    localparam logic [1:0]  OFF_STATUS = 2'd3;

    localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;
    localparam logic [11:0] WIN_TAG   = CFG_BASE[14:3];

    logic [1:0]  state_q, state_d;
    logic [15:0] sh_min_q, sh_min_d;
    logic [15:0] sh_max_q, sh_max_d;
    logic [15:0] er_min_q, er_min_d;
    logic [15:0] er_max_q, er_max_d;
    logic        er_valid_q, er_valid_d;
    logic        err_q, err_d;
    logic        locked;

    logic        in_win;
    logic [1:0]  off;
    logic        trusted;
    logic        wr_ok;
    logic        commit_req;
    logic        bounds_ok;

    assign in_win     = (per_addr[13:2] == WIN_TAG);
    assign off        = per_addr[1:0];
    assign trusted    = (pc >= SMEM_BASE) && (pc <= SMEM_LAST);
    assign wr_ok      = per_en && (per_we != 2'b00) && in_win && trusted &&
                        !locked && (state_q == ST_IDLE);
    assign commit_req = wr_ok && (off == OFF_CTRL) && per_din[0];

    // Overlap test: ranges intersect unless one lies wholly below the other.
    assign bounds_ok  = (sh_min_q <= sh_max_q) && !sh_min_q[0] && !sh_max_q[0] &&
                        (sh_min_q != 16'h0000) &&
                        !((sh_min_q <= SMEM_LAST) && (sh_max_q >= SMEM_BASE));

`ifdef CASU_ER_LOCK_EN
    logic lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (wr_ok && (off == OFF_CTRL) && per_din[1]) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sh_min_q   <= 16'hFFFF;
            sh_max_q   <= 16'h0000;
            er_min_q   <= 16'hFFFF;
            er_max_q   <= 16'h0000;
            er_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_min_q   <= sh_min_d;
            sh_max_q   <= sh_max_d;
            er_min_q   <= er_min_d;
            er_max_q   <= er_max_d;
            er_valid_q <= er_valid_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (commit_req) state_d = ST_CHECK;
            ST_CHECK: state_d = bounds_ok ? ST_APPLY : ST_ERR;
            ST_APPLY: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        sh_min_d   = sh_min_q;
        sh_max_d   = sh_max_q;
        er_min_d   = er_min_q;
        er_max_d   = er_max_q;
        er_valid_d = er_valid_q;
        err_d      = err_q;

        if (wr_ok && (off == OFF_SH_MIN)) sh_min_d = per_din;
        if (wr_ok && (off == OFF_SH_MAX)) sh_max_d = per_din;
        if (commit_req)                   err_d    = 1'b0;

        case (state_q)
            ST_APPLY: begin
                er_min_d   = sh_min_q;
                er_max_d   = sh_max_q;
                er_valid_d = 1'b1;
            end
            ST_ERR:   err_d = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        per_dout = 16'h0000;
        if (per_en && in_win) begin
            case (off)
                OFF_SH_MIN: per_dout = sh_min_q;
                OFF_SH_MAX: per_dout = sh_max_q;
                OFF_STATUS: per_dout = {12'h000, (state_q != ST_IDLE), err_q,
                                        locked, er_valid_q};
                default:    per_dout = 16'h0000;
            endcase
        end
    end

    assign ER_min   = er_min_q;
    assign ER_max   = er_max_q;
    assign er_valid = er_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_casu_er_cfg.sv
// ============================================================================
// Module   : tb_casu_er_cfg
// Brief    : Self-checking bench for casu_er_cfg against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_casu_er_cfg;

`ifdef CASU_ER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [15:0] pc;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] ER_min;
    logic [15:0] ER_max;
    logic        er_valid;

    int tests;
    int fails;

    casu_er_cfg dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pc       (pc),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout),
        .ER_min   (ER_min),
        .ER_max   (ER_max),
        .er_valid (er_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_sh_min, m_sh_max, m_er_min, m_er_max;
    bit          m_valid, m_err, m_lock, m_pend_ok;
    int          m_busy;

    function automatic bit m_trusted(input logic [15:0] p);
        return (p >= 16'hA000) && (p <= 16'hDFFE);
    endfunction

    function automatic bit m_bounds(input logic [15:0] lo, input logic [15:0] hi);
        bit disjoint;
        disjoint = (hi < 16'hA000) || (lo > 16'hDFFE);
        return (lo <= hi) && (lo % 2 == 0) && (hi % 2 == 0) && (lo != 0) && disjoint;
    endfunction

    function automatic logic [15:0] m_status();
        return {12'h000, (m_busy != 0), m_err, m_lock, m_valid};
    endfunction

    task automatic model_reset();
        m_sh_min = 16'hFFFF; m_sh_max = 16'h0000;
        m_er_min = 16'hFFFF; m_er_max = 16'h0000;
        m_valid = 0; m_err = 0; m_lock = 0; m_busy = 0; m_pend_ok = 0;
    endtask

    task automatic model_tick(input logic en, input logic [1:0] we, input logic [13:0] a,
                              input logic [15:0] d, input logic [15:0] p);
        bit acc;
        int o;
        acc = en && (we != 0) && (a >= 14'h00A0) && (a <= 14'h00A3) &&
              m_trusted(p) && !m_lock && (m_busy == 0);
        o = int'(a) - 'hA0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (m_pend_ok) begin
                    m_er_min = m_sh_min; m_er_max = m_sh_max; m_valid = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        if (acc) begin
            if (o == 0) m_sh_min = d;
            if (o == 1) m_sh_max = d;
            if (o == 2 && d[0]) begin
                m_err = 0; m_busy = 2; m_pend_ok = m_bounds(m_sh_min, m_sh_max);
            end
            if (o == 2 && d[1] && LOCK_EN) m_lock = 1;
        end
    endtask

    // ---------------- bus tasks (start/end at posedge+1) ----------------
    task automatic bus_cycle(input logic en, input logic [1:0] we, input logic [13:0] a,
                             input logic [15:0] d, input logic [15:0] p);
        per_en = en; per_we = we; per_addr = a; per_din = d; pc = p;
        @(posedge clk);
        model_tick(en, we, a, d, p);
        #1;
        per_en = 0; per_we = 0;
    endtask

    task automatic bus_write(input int off, input logic [15:0] d, input logic [15:0] p);
        bus_cycle(1'b1, 2'b11, 14'(14'h00A0 + off), d, p);
    endtask

    task automatic idle_cycle();
        bus_cycle(1'b0, 2'b00, 14'h0000, 16'h0000, pc);
    endtask

    task automatic read_reg(input int off, output logic [15:0] d);
        per_addr = 14'(14'h00A0 + off); per_we = 0; per_en = 1;
        #1;
        d = per_dout;
        per_en = 0;
    endtask

    task automatic reset_pulse();
        reset_n = 0;
        #3;
        model_reset();
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] s;
        bus_write(0, 16'h1234, 16'hA000);
        reset_n = 0;
        #1;
        model_reset();
        read_reg(3, s);
        tests++;
        if ({ER_min, ER_max, er_valid, s} !== {16'hFFFF, 16'h0000, 1'b0, 16'h0000}) begin
            fails++;
            $display("FAIL reset_outputs: got %h/%h/%b st=%h want FFFF/0000/0 st=0000",
                     ER_min, ER_max, er_valid, s);
        end
        read_reg(0, s);
        tests++;
        if (s !== 16'hFFFF) begin
            fails++; $display("FAIL reset_sh_min: got %h want FFFF", s);
        end
        #1 reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_valid_commit();
        logic [15:0] s;
        bus_write(0, 16'hE000, 16'hA010);
        bus_write(1, 16'hE0FE, 16'hA010);
        bus_write(2, 16'h0001, 16'hA010);           // cycle N
        read_reg(3, s);                              // N+1
        tests++;
        if (s !== 16'h0008) begin
            fails++; $display("FAIL commit_busy_n1: status %h want 0008", s);
        end
        idle_cycle();                                // N+2
        read_reg(3, s);
        tests++;
        if ({s, er_valid, ER_min} !== {16'h0008, 1'b0, 16'hFFFF}) begin
            fails++; $display("FAIL commit_n2: status %h valid %b min %h want 0008/0/FFFF",
                              s, er_valid, ER_min);
        end
        idle_cycle();                                // N+3
        read_reg(3, s);
        tests++;
        if ({ER_min, ER_max, er_valid, s} !== {16'hE000, 16'hE0FE, 1'b1, 16'h0001}) begin
            fails++; $display("FAIL commit_n3: got %h/%h/%b st=%h want E000/E0FE/1 st=0001",
                              ER_min, ER_max, er_valid, s);
        end
    endtask

    task automatic test_untrusted();
        logic [15:0] s;
        bus_write(0, 16'h0200, 16'hE010);
        read_reg(0, s);
        tests++;
        if (s !== 16'hE000) begin
            fails++; $display("FAIL untrusted_write: sh_min %h want E000", s);
        end
        bus_write(2, 16'h0001, 16'hE010);
        read_reg(3, s);
        tests++;
        if (s[3] !== 1'b0) begin
            fails++; $display("FAIL untrusted_commit: busy %b want 0", s[3]);
        end
        idle_cycle(); idle_cycle();
    endtask

    task automatic test_invalid();
        logic [15:0] lo [3] = '{16'hE100, 16'hE001, 16'h9000};
        logic [15:0] hi [3] = '{16'hE000, 16'hE0FE, 16'hA100};
        logic [15:0] s;
        for (int i = 0; i < 3; i++) begin
            bus_write(0, lo[i], 16'hA010);
            bus_write(1, hi[i], 16'hA010);
            bus_write(2, 16'h0001, 16'hA010);
            idle_cycle(); idle_cycle();
            read_reg(3, s);
            tests++;
            if ({s[2], ER_min, ER_max, er_valid} !== {1'b1, 16'hE000, 16'hE0FE, 1'b1}) begin
                fails++; $display("FAIL invalid_%0d: err %b er %h/%h v %b want 1 E000/E0FE 1",
                                  i, s[2], ER_min, ER_max, er_valid);
            end
        end
    endtask

    task automatic test_write_busy();
        logic [15:0] s;
        bus_write(0, 16'hE100, 16'hA010);
        bus_write(1, 16'hE200, 16'hA010);
        bus_write(2, 16'h0001, 16'hA010);
        bus_write(1, 16'h1234, 16'hA010);
        idle_cycle();
        read_reg(1, s);
        tests++;
        if ({ER_min, ER_max, s} !== {16'hE100, 16'hE200, 16'hE200}) begin
            fails++; $display("FAIL write_busy: er %h/%h sh_max %h want E100/E200/E200",
                              ER_min, ER_max, s);
        end
    endtask

    task automatic test_reset_midcommit();
        bus_write(0, 16'h0400, 16'hA010);
        bus_write(1, 16'h0500, 16'hA010);
        bus_write(2, 16'h0001, 16'hA010);
        idle_cycle();                                // in APPLY now
        reset_n = 0;
        #1;
        tests++;
        if ({ER_min, ER_max, er_valid} !== {16'hFFFF, 16'h0000, 1'b0}) begin
            fails++; $display("FAIL reset_mid: er %h/%h v %b want FFFF/0000/0",
                              ER_min, ER_max, er_valid);
        end
        #2;
        model_reset();
        reset_n = 1;
        @(posedge clk); #1;
        idle_cycle(); idle_cycle();
        tests++;
        if ({ER_min, ER_max, er_valid} !== {16'hFFFF, 16'h0000, 1'b0}) begin
            fails++; $display("FAIL reset_mid_after: er %h/%h v %b want FFFF/0000/0",
                              ER_min, ER_max, er_valid);
        end
    endtask

    function automatic logic [15:0] rand_data();
        case ($urandom_range(0, 4))
            0:       return 16'($urandom_range(1, 16'h4FFF) * 2);
            1:       return 16'($urandom_range(16'h7000, 16'h7FFF) * 2);
            2:       return 16'h9FFE + 16'($urandom_range(0, 4));
            3:       return 16'hDFFE + 16'($urandom_range(0, 4));
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] rand_pc();
        logic [15:0] pcs [6] = '{16'hA000, 16'hDFFE, 16'hDFFF, 16'h9FFE, 16'hE000, 16'h0000};
        case ($urandom_range(0, 3))
            0:       return pcs[$urandom_range(0, 5)];
            1:       return 16'($urandom);
            default: return 16'($urandom_range(16'hA000, 16'hDFFE));
        endcase
    endfunction

    task automatic test_random();
        logic [15:0] s0, s1, st, d;
        logic [13:0] a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 14'($urandom) : 14'(14'h00A0 + $urandom_range(0, 3));
            d = (a == 14'h00A2) ? 16'($urandom_range(0, 1)) : rand_data();
            if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(0, 1));
            if (a == 14'h00A2 && $urandom_range(0, 1) == 0) d = 16'h0001;
            if ($urandom_range(0, 4) == 0) idle_cycle();
            else bus_cycle(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                           a, (a == 14'h00A2) ? (d & 16'hFFFD) : d, rand_pc());
            read_reg(0, s0);
            read_reg(1, s1);
            read_reg(3, st);
            tests++;
            if ({ER_min, ER_max, er_valid, s0, s1, st} !==
                {m_er_min, m_er_max, m_valid, m_sh_min, m_sh_max, m_status()}) begin
                fails++;
                $display("FAIL random_%0d: er %h/%h v%b sh %h/%h st %h want %h/%h v%b sh %h/%h st %h",
                         i, ER_min, ER_max, er_valid, s0, s1, st,
                         m_er_min, m_er_max, m_valid, m_sh_min, m_sh_max, m_status());
            end
        end
        idle_cycle(); idle_cycle();
    endtask

    task automatic test_lock();
        logic [15:0] s;
        bus_write(0, 16'hE000, 16'hA010);
        bus_write(1, 16'hE0FE, 16'hA010);
        bus_write(2, 16'h0003, 16'hA010);
        idle_cycle(); idle_cycle();
        read_reg(3, s);
        tests++;
        if (s !== (LOCK_EN ? 16'h0003 : 16'h0001) || s !== m_status()) begin
            fails++; $display("FAIL lock_status: got %h want %h", s, m_status());
        end
        bus_write(0, 16'h0400, 16'hA010);
        read_reg(0, s);
        tests++;
        if (s !== (LOCK_EN ? 16'hE000 : 16'h0400) || s !== m_sh_min) begin
            fails++; $display("FAIL lock_blocks_write: sh_min %h want %h", s, m_sh_min);
        end
        reset_pulse();
        bus_write(0, 16'h0600, 16'hA010);
        read_reg(3, s);
        tests++;
        if (s[1] !== 1'b0) begin
            fails++; $display("FAIL lock_after_reset: lock %b want 0", s[1]);
        end
        read_reg(0, s);
        tests++;
        if (s !== 16'h0600) begin
            fails++; $display("FAIL lock_cleared_write: sh_min %h want 0600", s);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset_n = 0; pc = 16'h0000; per_addr = 0; per_din = 0; per_en = 0; per_we = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
        test_reset();
        test_valid_commit();
        test_untrusted();
        test_invalid();
        test_write_busy();
        test_reset_midcommit();
        test_random();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
